// File: rtl/matrix_job_ctrl_pkg.sv
// Shared types and constants for the matrix job controller: FSM encoding,
// engine-select values and buffer geometry.
package matrix_job_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISPATCH,
    S_WAIT,
    S_DRAIN
  } state_t;

  localparam logic MODE_SW     = 1'b0;
  localparam logic MODE_HW     = 1'b1;
  localparam int   N_WORDS_DEF = 4;
  localparam int   DATA_W      = 16;
  localparam int   ADDR_W      = 4;

  function automatic logic [ADDR_W-1:0] last_idx(input int n);
    return ADDR_W'(n - 1);
  endfunction

endpackage

// File: rtl/matrix_job_ctrl_if.sv
// Operand, engine, result and status signals of the matrix job controller.
// 'master' is the controller side, 'slave' is the surrounding system/engine.
interface matrix_job_ctrl_if;
  import matrix_job_ctrl_pkg::*;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              mode_i;
  logic              eng_start_o;
  logic              eng_sel_o;
  logic [ADDR_W-1:0] eng_rd_addr_i;
  logic [DATA_W-1:0] eng_rd_data_o;
  logic              eng_res_valid_i;
  logic [DATA_W-1:0] eng_res_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              busy_o;
  logic              err_o;
  logic [15:0]       job_count_o;

  modport master (
    input  in_valid_i, in_data_i, mode_i, eng_rd_addr_i,
           eng_res_valid_i, eng_res_data_i, out_ready_i,
    output in_ready_o, eng_start_o, eng_sel_o, eng_rd_data_o,
           out_valid_o, out_data_o, busy_o, err_o, job_count_o
  );

  modport slave (
    output in_valid_i, in_data_i, mode_i, eng_rd_addr_i,
           eng_res_valid_i, eng_res_data_i, out_ready_i,
    input  in_ready_o, eng_start_o, eng_sel_o, eng_rd_data_o,
           out_valid_o, out_data_o, busy_o, err_o, job_count_o
  );

endinterface

// File: rtl/matrix_job_ctrl_job_buf.sv
// Small word buffer: one synchronous write port, one asynchronous read port.
// Reads beyond DEPTH return zero.
module job_buf
  import matrix_job_ctrl_pkg::*;
#(
  parameter int DEPTH = N_WORDS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) mem_q[i] <= wdata;
      end
    end
  end

  // Address decode by comparison keeps out-of-range reads at zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) rdata = mem_q[i];
    end
  end

endmodule

// File: rtl/matrix_job_ctrl.sv
// Matrix job controller: collects N_WORDS operands, dispatches them to the
// selected engine, gathers N_WORDS results with a timeout, then streams them out.
module matrix_job_ctrl
  import matrix_job_ctrl_pkg::*;
#(
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  matrix_job_ctrl_if.master bus
);

  localparam int                TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = last_idx(N_WORDS);

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] rd_idx_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              in_ready_q;
  logic              eng_start_q;
  logic              eng_sel_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              err_q;
  logic [15:0]       job_count_q;

  logic              in_fire;
  logic              res_fire;
  logic [ADDR_W-1:0] op_waddr;
  logic [ADDR_W-1:0] res_raddr;
  logic [DATA_W-1:0] res_rdata;

  assign in_fire  = bus.in_valid_i && in_ready_q;
  assign res_fire = (state_q == S_WAIT) && bus.eng_res_valid_i;
  assign op_waddr = (state_q == S_LOAD) ? idx_q : '0;
  // In DRAIN the buffer is read one word ahead so the next word is ready to
  // register on each handshake; elsewhere word 0 is prefetched for DRAIN entry.
  assign res_raddr = (state_q == S_DRAIN) ? rd_idx_q + ADDR_W'(1) : '0;

  job_buf #(.DEPTH(N_WORDS)) u_op_buf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (in_fire),
    .waddr (op_waddr),
    .wdata (bus.in_data_i),
    .raddr (bus.eng_rd_addr_i),
    .rdata (bus.eng_rd_data_o)
  );

  job_buf #(.DEPTH(N_WORDS)) u_res_buf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (res_fire),
    .waddr (idx_q),
    .wdata (bus.eng_res_data_i),
    .raddr (res_raddr),
    .rdata (res_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b1;
      eng_start_q <= 1'b0;
      eng_sel_q   <= MODE_SW;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      job_count_q <= '0;
    end else begin
      eng_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_fire) begin
            eng_sel_q <= bus.mode_i;
            err_q     <= 1'b0;
            idx_q     <= ADDR_W'(1);
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_fire) begin
            if (idx_q == LAST_IDX) begin
              idx_q       <= '0;
              in_ready_q  <= 1'b0;
              eng_start_q <= 1'b1;
              state_q     <= S_DISPATCH;
            end else begin
              idx_q <= idx_q + ADDR_W'(1);
            end
          end
        end
        S_DISPATCH: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.eng_res_valid_i) begin
            tmo_q <= '0;
            if (idx_q == LAST_IDX) begin
              idx_q       <= '0;
              rd_idx_q    <= '0;
              out_valid_q <= 1'b1;
              out_data_q  <= res_rdata;
              state_q     <= S_DRAIN;
            end else begin
              idx_q <= idx_q + ADDR_W'(1);
            end
          end else if (tmo_q == TMO_LAST) begin
            // Engine went silent: abandon the job, leave err set for software.
            err_q      <= 1'b1;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_DRAIN: begin
          if (bus.out_ready_i) begin
            if (rd_idx_q == LAST_IDX) begin
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              job_count_q <= job_count_q + 16'd1;
              in_ready_q  <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              rd_idx_q   <= rd_idx_q + ADDR_W'(1);
              out_data_q <= res_rdata;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.eng_start_o = eng_start_q;
  assign bus.eng_sel_o   = eng_sel_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.err_o       = err_q;
  assign bus.job_count_o = job_count_q;

endmodule

// File: tb/tb_matrix_job_ctrl.sv
// Randomized self-checking bench for matrix_job_ctrl; the bench plays both the
// operand source, the engine and the result sink.
module tb_matrix_job_ctrl;
  import matrix_job_ctrl_pkg::*;

  localparam int NW  = N_WORDS_DEF;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_job_ctrl_if bus ();

  matrix_job_ctrl #(.N_WORDS(NW), .TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] ops [NW];
  logic [15:0] exp_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Engine behaviour chosen by the bench; results are derived from the
  // operands the bench sent, not from what the DUT hands back.
  function automatic logic [15:0] engine_fn(input logic sel, input logic [15:0] x);
    return (sel == MODE_HW) ? ((x ^ 16'h5A5A) + 16'd3) : (x * 16'd10);
  endfunction

  task automatic idle_inputs();
    bus.in_valid_i      = 1'b0;
    bus.in_data_i       = '0;
    bus.mode_i          = 1'b0;
    bus.eng_rd_addr_i   = '0;
    bus.eng_res_valid_i = 1'b0;
    bus.eng_res_data_i  = '0;
    bus.out_ready_i     = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_word(input logic [15:0] d, input logic m, output bit ok);
    int n = 0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    bus.mode_i     = m;
    while (!bus.in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready_o;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = 16'(~d);
    bus.mode_i     = 1'($urandom);
  endtask

  task automatic random_ops();
    for (int i = 0; i < NW; i++) ops[i] = 16'($urandom);
  endtask

  // mode_pat: 0 hold, 1 invert, 2 random after word 0
  // rdy_pat : 0 always ready, 1 toggle starting low, 2 random
  // rst_after >= 0 resets the DUT after that many results have been returned
  task automatic run_job(input logic m0, input int mode_pat, input int rdy_pat,
                         input bit silent, input int rst_after, input bit junk);
    logic [15:0] res [NW];
    logic [15:0] got [$];
    logic [15:0] prev_data;
    logic [15:0] exp_rd;
    logic [3:0]  addr;
    logic        m, rdy, prev_stall;
    bit          ok;
    int          n, since;

    for (int i = 0; i < NW; i++) res[i] = engine_fn(m0, ops[i]);

    for (int i = 0; i < NW; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      case (mode_pat)
        0:       m = m0;
        1:       m = ~m0;
        default: m = 1'($urandom);
      endcase
      if (i == 0) m = m0;
      send_word(ops[i], m, ok);
      chk("in_handshake", ok, 1);
      if (i == 0) begin
        chk("err_cleared", bus.err_o, 0);
        chk("sel_latched", bus.eng_sel_o, m0);
        chk("busy_load", bus.busy_o, 1);
      end
    end

    n = 0;
    while (!bus.eng_start_o && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("start_latency", n, 0);
    chk("ready_dispatch", bus.in_ready_o, 0);
    since = 0;
    @(negedge clk);
    since++;
    chk("start_one_cycle", bus.eng_start_o, 0);
    chk("sel_hold", bus.eng_sel_o, m0);

    for (int a = 0; a < NW + 2; a++) begin
      if (a < NW)       addr = 4'(a);
      else if (a == NW) addr = 4'(NW);
      else              addr = 4'd15;
      bus.eng_rd_addr_i = addr;
      exp_rd = (a < NW) ? ops[a] : 16'd0;
      #1;
      chk("op_readback", bus.eng_rd_data_o, exp_rd);
      @(negedge clk);
      since++;
    end

    if (silent) begin
      while (bus.busy_o && since < TMO + 20) begin
        @(negedge clk);
        since++;
      end
      chk("timeout_cycles", since, TMO + 1);
      chk("timeout_err", bus.err_o, 1);
      chk("timeout_busy", bus.busy_o, 0);
      chk("timeout_count", bus.job_count_o, exp_count);
      chk("timeout_ready", bus.in_ready_o, 1);
      return;
    end

    for (int i = 0; i < NW; i++) begin
      if (i == rst_after) begin
        rst = 1'b1;
        bus.eng_rd_addr_i = '0;
        #1;
        chk("rst_start", bus.eng_start_o, 0);
        chk("rst_sel", bus.eng_sel_o, 0);
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_out_data", bus.out_data_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_count", bus.job_count_o, 0);
        chk("rst_buf_clear", bus.eng_rd_data_o, 0);
        exp_count = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.in_ready_o, 1);
        return;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i == 0) chk("ready_wait", bus.in_ready_o, 0);
      bus.eng_res_valid_i = 1'b1;
      bus.eng_res_data_i  = res[i];
      @(negedge clk);
      bus.eng_res_valid_i = junk && (i == NW - 1);
      bus.eng_res_data_i  = 16'hDEAD;
    end

    got.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    n = 0;
    while (got.size() < NW && n < 8 * NW) begin
      case (rdy_pat)
        0:       rdy = 1'b1;
        1:       rdy = n[0];
        default: rdy = 1'($urandom);
      endcase
      if (prev_stall) chk("out_hold", bus.out_data_o, prev_data);
      bus.out_ready_i = rdy;
      if (bus.out_valid_o && rdy) got.push_back(bus.out_data_o);
      prev_stall = bus.out_valid_o && !rdy;
      prev_data  = bus.out_data_o;
      @(negedge clk);
      n++;
    end
    bus.out_ready_i     = 1'b0;
    bus.eng_res_valid_i = 1'b0;
    chk("out_count", got.size(), NW);
    for (int i = 0; i < got.size() && i < NW; i++) chk("out_word", got[i], res[i]);

    exp_count = exp_count + 16'd1;
    chk("done_busy", bus.busy_o, 0);
    chk("done_count", bus.job_count_o, exp_count);
    chk("done_valid", bus.out_valid_o, 0);
    chk("done_ready", bus.in_ready_o, 1);
    chk("done_err", bus.err_o, 0);
  endtask

  initial begin
    idle_inputs();
    exp_count = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_start", bus.eng_start_o, 0);
    chk("reset_sel", bus.eng_sel_o, 0);
    chk("reset_out_valid", bus.out_valid_o, 0);
    chk("reset_out_data", bus.out_data_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_err", bus.err_o, 0);
    chk("reset_count", bus.job_count_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", bus.in_ready_o, 1);

    // Directed SW job: 1,2,3,4 -> 10,20,30,40
    for (int i = 0; i < NW; i++) ops[i] = 16'(i + 1);
    run_job(MODE_SW, 0, 0, 1'b0, -1, 1'b0);

    // HW selected on word 0 only, later mode changes ignored
    random_ops();
    run_job(MODE_HW, 1, 2, 1'b0, -1, 1'b0);

    // Silent engine, sticky error, cleared by next job's first word
    random_ops();
    run_job(1'($urandom), 2, 0, 1'b1, -1, 1'b0);
    repeat (5) @(negedge clk);
    chk("err_sticky", bus.err_o, 1);
    random_ops();
    run_job(MODE_SW, 2, 2, 1'b0, -1, 1'b0);

    // Toggling out_ready, stray engine results during DRAIN
    random_ops();
    run_job(MODE_SW, 0, 1, 1'b0, -1, 1'b1);

    // Reset mid-WAIT, then a fresh job
    random_ops();
    run_job(MODE_HW, 0, 2, 1'b0, 2, 1'b0);
    random_ops();
    run_job(MODE_HW, 2, 2, 1'b0, -1, 1'b0);

    // Counter wrap from a preset value
    @(negedge clk);
    force dut.job_count_q = 16'hFFFF;
    #1;
    release dut.job_count_q;
    exp_count = 16'hFFFF;
    @(negedge clk);
    chk("count_preset", bus.job_count_o, 16'hFFFF);
    random_ops();
    run_job(MODE_SW, 0, 0, 1'b0, -1, 1'b0);
    chk("count_wrapped", bus.job_count_o, 0);

    repeat (6) begin
      random_ops();
      run_job(1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
              1'b0, -1, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got=running exp=finished");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
